// File: rtl/simple_pkg.sv
// Shared types and defaults for the SIMPLE core pipeline control logic.
// tag_t describes one in-flight instruction as seen by the hazard unit.
package simple_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 3;
  // Tags hold register addresses zero-extended to this width so one struct serves any RADDR_W.
  localparam int TAG_RD_W    = 8;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic                wren;
    logic [TAG_RD_W-1:0] rd;
    logic                is_load;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  function automatic logic tag_match(input tag_t t, input logic [TAG_RD_W-1:0] r);
    return t.valid & t.wren & (t.rd == r);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority encoder for one operand: the youngest matching producer wins,
// no match selects the register file.
module fwd_select
  import simple_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  localparam int SEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0] match,
  output logic [SEL_W-1:0]   sel
);

  // Scan oldest to youngest so the smallest matching index is the last assignment.
  always_comb begin
    sel = SEL_W'(SEL_REGFILE);
    for (int j = NUM_SRC; j >= 1; j--) begin
      if (match[j-1]) begin
        sel = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control: tracks in-flight destination tags,
// stalls on load-use, flushes on taken branches, and drives EX operand muxes.
module hazard_fwd_ctrl
  import simple_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int RADDR_W  = DEF_RADDR_W,
  parameter  int NUM_SRC  = 2,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(NUM_SRC + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stop,
  input  logic                      branch_taken,
  input  logic                      id_valid,
  input  logic [RADDR_W-1:0]        id_rs,
  input  logic [RADDR_W-1:0]        id_rt,
  input  logic                      id_rs_used,
  input  logic                      id_rt_used,
  input  logic                      id_wren,
  input  logic [RADDR_W-1:0]        id_rd,
  input  logic                      id_is_load,
  input  logic [DATA_W-1:0]         rf_a,
  input  logic [DATA_W-1:0]         rf_b,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      pc_wren,
  output logic                      ir_wren,
  output logic                      ir_flush,
  output logic                      ex_flush,
  output logic [SEL_W-1:0]          fwd_sel_a,
  output logic [SEL_W-1:0]          fwd_sel_b,
  output logic [DATA_W-1:0]         op_a,
  output logic [DATA_W-1:0]         op_b,
  output logic [15:0]               stall_count
);

  localparam int DEPTH = NUM_SRC + 1;

  tag_t              tag_q [1:DEPTH];
  tag_t              tag_d [1:DEPTH];
  logic [SEL_W-1:0]  fwd_sel_a_q, fwd_sel_a_d;
  logic [SEL_W-1:0]  fwd_sel_b_q, fwd_sel_b_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic [DEPTH:1]    hit_a, hit_b, is_ld, lat_mask;
  logic [SEL_W-1:0]  sel_a_raw, sel_b_raw;
  logic              load_use, bubble;
  logic [DATA_W-1:0] src_arr [1:NUM_SRC];

  // Entry gi holds the instruction gi stages ahead of the one currently in ID.
  for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
    assign hit_a[gi]    = tag_match(tag_q[gi], TAG_RD_W'(id_rs));
    assign hit_b[gi]    = tag_match(tag_q[gi], TAG_RD_W'(id_rt));
    assign is_ld[gi]    = tag_q[gi].is_load;
    assign lat_mask[gi] = (gi <= LOAD_LAT);
  end

  for (genvar gi = 1; gi <= NUM_SRC; gi++) begin : g_src
    assign src_arr[gi] = src_data[gi*DATA_W-1 -: DATA_W];
  end

  assign load_use = id_valid &
                    ((id_rs_used & |(hit_a & is_ld & lat_mask)) |
                     (id_rt_used & |(hit_b & is_ld & lat_mask)));
  assign bubble   = load_use | branch_taken;

  always_comb begin
    pc_wren  = 1'b1;
    ir_wren  = 1'b1;
    ir_flush = 1'b0;
    ex_flush = 1'b0;
    if (branch_taken) begin
      ir_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (load_use) begin
      pc_wren  = 1'b0;
      ir_wren  = 1'b0;
      ex_flush = 1'b1;
    end
  end

  fwd_select #(.NUM_SRC(NUM_SRC)) u_sel_a (
    .match (hit_a[NUM_SRC:1]),
    .sel   (sel_a_raw)
  );

  fwd_select #(.NUM_SRC(NUM_SRC)) u_sel_b (
    .match (hit_b[NUM_SRC:1]),
    .sel   (sel_b_raw)
  );

  always_comb begin
    tag_d[1] = TAG_BUBBLE;
    if (!bubble) begin
      tag_d[1].valid   = id_valid;
      tag_d[1].wren    = id_wren;
      tag_d[1].rd      = TAG_RD_W'(id_rd);
      tag_d[1].is_load = id_is_load;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    fwd_sel_a_d = (bubble | ~id_rs_used) ? SEL_W'(SEL_REGFILE) : sel_a_raw;
    fwd_sel_b_d = (bubble | ~id_rt_used) ? SEL_W'(SEL_REGFILE) : sel_b_raw;

    stall_count_d = stall_count_q;
    if (load_use && !branch_taken && stall_count_q != 16'hFFFF) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Reset takes priority over stop so a frozen pipeline can still be cleared.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        tag_q[k] <= TAG_BUBBLE;
      end
      fwd_sel_a_q   <= SEL_W'(SEL_REGFILE);
      fwd_sel_b_q   <= SEL_W'(SEL_REGFILE);
      stall_count_q <= 16'd0;
    end else if (!stop) begin
      for (int k = 1; k <= DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
      fwd_sel_a_q   <= fwd_sel_a_d;
      fwd_sel_b_q   <= fwd_sel_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    for (int j = 1; j <= NUM_SRC; j++) begin
      if (fwd_sel_a_q == SEL_W'(j)) op_a = src_arr[j];
      if (fwd_sel_b_q == SEL_W'(j)) op_b = src_arr[j];
    end
  end

  assign fwd_sel_a   = fwd_sel_a_q;
  assign fwd_sel_b   = fwd_sel_b_q;
  assign stall_count = stall_count_q;

endmodule
